pio_button_led_slave: RTL and testbench
=======================================

// Module: pio_button_led_slave
// PURPOSE
//  Avalon-MM responder hanging off the PCIe host bridge: the host writes an LED register and
//  reads debounced push-button state, latched button presses (edge capture) and an interrupt mask.
//  Drives the board LEDs, samples the asynchronous keys and raises irq on unmasked presses.
//  Sits in the clk_clk domain beside the system interconnect; one agent, 4 word registers.
// PARAMETERS
//  WIDTH           4      number of LEDs and number of buttons (1..32)
//  DEBOUNCE_CYCLES 50000  consecutive stable clk_clk cycles required to accept a button level (>=2)
//  DEB_CNT_W       16     debounce counter width; must hold DEBOUNCE_CYCLES-1
// PORTS
//  clk_clk            in   1      system clock; all logic on rising edge
//  reset_reset        in   1      synchronous reset, active-high
//  avs_address        in   2      word address: 0 LED, 1 BUTTON, 2 IRQ_MASK, 3 EDGE_CAPTURE
//  avs_read           in   1      read strobe, 1-cycle
//  avs_readdata       out  32     read data, valid when avs_readdatavalid=1
//  avs_readdatavalid  out  1      high exactly 1 cycle after an accepted read
//  avs_write          in   1      write strobe, 1-cycle
//  avs_writedata      in   32     write data; bits above WIDTH ignored
//  irq                out  1      level interrupt: |(edge_capture & irq_mask)
//  led_export         out  WIDTH  LED drive, 1 = lit
//  button_export      in   WIDTH  raw keys, asynchronous, active-low (0 = pressed)
// BEHAVIOUR
//  Reset (reset_reset=1 at a clock edge): led=0, irq_mask=0, edge_capture=0, sync FFs=all 1,
//   debounced=all 1, counters=0, avs_readdata=0, avs_readdatavalid=0, irq=0. Reset mid-transaction
//   drops any pending readdatavalid; no response is issued for a read accepted in the reset cycle.
//  No waitrequest: every read/write accepted the cycle it is asserted. Fixed read latency 1.
//   read and write asserted together: write performed, read returns pre-write value.
//  Input path per bit: 2-FF synchronizer -> sync[i]. Debounce per bit:
//   sync==debounced: cnt<=0. sync!=debounced: cnt<=cnt+1; when cnt==DEBOUNCE_CYCLES-1,
//   debounced<=sync, cnt<=0. Any bounce back to debounced before terminal count clears cnt.
//   Latency key change -> debounced change = 2 + DEBOUNCE_CYCLES cycles for a clean edge.
//  Edge capture: debounced[i] 1->0 (press) sets edge_capture[i] next cycle. Releases ignored.
//   Write to addr 3: bits written 1 clear, 0 unaffected. Set and clear same cycle: set wins.
//  Registers (readdata bits [31:WIDTH] always 0):
//   0 LED          RW  led_export = register, updates cycle after write.
//   1 BUTTON       RO  ~debounced (1 = pressed); writes ignored.
//   2 IRQ_MASK     RW  1 enables interrupt for that bit.
//   3 EDGE_CAPTURE R/W1C.
//  irq: combinational OR over registered edge_capture & irq_mask; no extra latency beyond those regs.
//   Clearing the last unmasked bit or writing mask=0 drops irq the cycle after the write.
//  Counters saturate never: reaching terminal count always reloads 0; no wrap ambiguity.
// TESTING  (WIDTH=4, DEBOUNCE_CYCLES=4)
//  1 Reset: hold reset 3 cycles -> led_export=0, irq=0, read addr1 -> 0x0, addr3 -> 0x0.
//  2 Write addr0=0xFFFF_FFF5 -> led_export=4'b0101 next cycle; read addr0 -> 0x5, valid 1 cycle later.
//  3 Clean press: button_export[2] 1->0 held -> BUTTON reads 0x4 after 6 cycles, edge_capture=0x4;
//    mask=0x0 -> irq=0; write addr2=0x4 -> irq=1 next cycle.
//  4 Bounce: toggle button_export[1] low 3 cycles then high, repeat 5x -> debounced/edge never
//    change; then hold low 10 cycles -> edge_capture[1]=1 exactly once.
//  5 W1C race: with edge[0]=1, write addr3=0x1 same cycle a new press of bit 0 debounces ->
//    edge[0] stays 1; next write addr3=0x1 alone -> edge[0]=0, irq drops next cycle.
//  6 Reset mid-operation: issue read, assert reset next cycle -> no readdatavalid; all regs at reset values.

Source files
------------

// File: rtl/pio_button_led_slave.sv
// pio_button_led_slave
// Avalon-MM register block for the board LEDs and push buttons.
// The host writes the LED register and reads debounced key state, latched key presses
// (edge capture, write-1-to-clear) and an interrupt mask. Keys are asynchronous and
// active-low. They are synchronised and debounced per bit before the rest of the logic
// sees them. irq is the OR of unmasked captured presses.
module pio_button_led_slave #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int DEB_CNT_W       = 16
) (
  input  logic             clk_clk,
  input  logic             reset_reset,
  input  logic [1:0]       avs_address,
  input  logic             avs_read,
  output logic [31:0]      avs_readdata,
  output logic             avs_readdatavalid,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  output logic             irq,
  output logic [WIDTH-1:0] led_export,
  input  logic [WIDTH-1:0] button_export
);

  localparam logic [1:0] ADDR_LED    = 2'd0;
  localparam logic [1:0] ADDR_BUTTON = 2'd1;
  localparam logic [1:0] ADDR_MASK   = 2'd2;
  localparam logic [1:0] ADDR_EDGE   = 2'd3;

  localparam logic [DEB_CNT_W-1:0] CNT_LAST = DEB_CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0]     led_reg;
  logic [WIDTH-1:0]     irq_mask;
  logic [WIDTH-1:0]     edge_capture;
  logic [WIDTH-1:0]     sync_meta;
  logic [WIDTH-1:0]     sync_q;
  logic [WIDTH-1:0]     debounced;
  logic [WIDTH-1:0]     deb_prev;
  logic [DEB_CNT_W-1:0] deb_cnt [WIDTH];

  logic [WIDTH-1:0] wr_data;
  logic             wr_led;
  logic             wr_mask;
  logic             wr_edge;
  logic [WIDTH-1:0] press;
  logic [WIDTH-1:0] edge_clear;
  logic [31:0]      read_word;

  // Write-data bits above WIDTH are dropped on purpose; this keeps the whole bus visibly consumed.
  logic [31:0] unused_wdata;
  assign unused_wdata = avs_writedata;

  assign wr_data = avs_writedata[WIDTH-1:0];
  assign wr_led  = avs_write && (avs_address == ADDR_LED);
  assign wr_mask = avs_write && (avs_address == ADDR_MASK);
  assign wr_edge = avs_write && (avs_address == ADDR_EDGE);

  // A press is a 1->0 transition of the debounced level. Releases are ignored.
  assign press      = deb_prev & ~debounced;
  assign edge_clear = wr_edge ? wr_data : '0;

  assign led_export = led_reg;
  assign irq        = |(edge_capture & irq_mask);

  // Two-flop synchroniser for the asynchronous keys. It idles high, which means not pressed.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      sync_meta <= '1;
      sync_q    <= '1;
    end else begin
      sync_meta <= button_export;
      sync_q    <= sync_meta;
    end
  end

  // Per-bit debounce: accept a new level only after it has held for DEBOUNCE_CYCLES samples.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      debounced <= '1;
      for (int i = 0; i < WIDTH; i++) begin
        deb_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync_q[i] == debounced[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == CNT_LAST) begin
          debounced[i] <= sync_q[i];
          deb_cnt[i]   <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DEB_CNT_W'(1);
        end
      end
    end
  end

  // Delayed copy of the debounced level, used to spot the press edge.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      deb_prev <= '1;
    end else begin
      deb_prev <= debounced;
    end
  end

  // Host-writable registers: LED and mask take the written value. Edge capture is W1C, and a new press beats a clear.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      led_reg      <= '0;
      irq_mask     <= '0;
      edge_capture <= '0;
    end else begin
      if (wr_led) begin
        led_reg <= wr_data;
      end
      if (wr_mask) begin
        irq_mask <= wr_data;
      end
      edge_capture <= (edge_capture & ~edge_clear) | press;
    end
  end

  // Read mux from the current register values. A simultaneous write therefore reads back the old value.
  always_comb begin
    read_word = '0;
    case (avs_address)
      ADDR_LED:    read_word[WIDTH-1:0] = led_reg;
      ADDR_BUTTON: read_word[WIDTH-1:0] = ~debounced;
      ADDR_MASK:   read_word[WIDTH-1:0] = irq_mask;
      ADDR_EDGE:   read_word[WIDTH-1:0] = edge_capture;
      default:     read_word = '0;
    endcase
  end

  // Fixed one-cycle read response. Reset suppresses any response that is pending or being accepted.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      avs_readdata      <= '0;
      avs_readdatavalid <= 1'b0;
    end else begin
      avs_readdatavalid <= avs_read;
      if (avs_read) begin
        avs_readdata <= read_word;
      end
    end
  end

endmodule

// File: tb/tb_pio_button_led_slave.sv
// tb_pio_button_led_slave
// Self-checking bench for the LED/button register block, built with a short debounce window.
// Read expectations go onto a queue when a read is issued. They are popped when readdatavalid returns.
module tb_pio_button_led_slave;

  localparam int WIDTH = 4;
  localparam int DEB   = 4;

  logic             clk_clk = 1'b0;
  logic             reset_reset = 1'b0;
  logic [1:0]       avs_address = '0;
  logic             avs_read = 1'b0;
  logic [31:0]      avs_readdata;
  logic             avs_readdatavalid;
  logic             avs_write = 1'b0;
  logic [31:0]      avs_writedata = '0;
  logic             irq;
  logic [WIDTH-1:0] led_export;
  logic [WIDTH-1:0] button_export = '1;

  int tests_run    = 0;
  int tests_failed = 0;
  logic [31:0] exp_q [$];

  pio_button_led_slave #(
    .WIDTH(WIDTH),
    .DEBOUNCE_CYCLES(DEB),
    .DEB_CNT_W(16)
  ) dut (
    .clk_clk(clk_clk),
    .reset_reset(reset_reset),
    .avs_address(avs_address),
    .avs_read(avs_read),
    .avs_readdata(avs_readdata),
    .avs_readdatavalid(avs_readdatavalid),
    .avs_write(avs_write),
    .avs_writedata(avs_writedata),
    .irq(irq),
    .led_export(led_export),
    .button_export(button_export)
  );

  // Free-running 100 MHz clock.
  always #5 clk_clk = ~clk_clk;

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic do_write(input logic [1:0] a, input logic [31:0] d);
    avs_address   = a;
    avs_writedata = d;
    avs_write     = 1'b1;
    tick();
    avs_write = 1'b0;
  endtask

  // Issue one read, then check the response cycle and the cycle after it.
  task automatic do_read(input logic [1:0] a, input logic [31:0] exp, input string name);
    logic [31:0] e;
    avs_address = a;
    avs_read    = 1'b1;
    exp_q.push_back(exp);
    tick();
    avs_read = 1'b0;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    tests_run++;
    if (avs_readdatavalid !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL %s valid: got %b expected 1", name, avs_readdatavalid);
    end else if (avs_readdata !== e) begin
      tests_failed++;
      $display("[TB] FAIL %s data: got 0x%08h expected 0x%08h", name, avs_readdata, e);
    end
    tick();
    tests_run++;
    if (avs_readdatavalid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL %s valid_len: got %b expected 0", name, avs_readdatavalid);
    end
  endtask

  task automatic test_reset();
    reset_reset = 1'b1;
    repeat (3) tick();
    reset_reset = 1'b0;
    tests_run++;
    if (led_export !== 4'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_led: got 0x%0h expected 0x0", led_export);
    end
    tests_run++;
    if (irq !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_irq: got %b expected 0", irq);
    end
    do_read(2'd0, 32'h0, "reset_rd_led");
    do_read(2'd1, 32'h0, "reset_rd_button");
    do_read(2'd2, 32'h0, "reset_rd_mask");
    do_read(2'd3, 32'h0, "reset_rd_edge");
  endtask

  task automatic test_led_write();
    do_write(2'd0, 32'hFFFF_FFF5);
    tests_run++;
    if (led_export !== 4'b0101) begin
      tests_failed++;
      $display("[TB] FAIL led_export: got 0x%0h expected 0x5", led_export);
    end
    do_read(2'd0, 32'h5, "led_readback");
    do_write(2'd1, 32'h0000_000F);
    do_read(2'd1, 32'h0, "button_ro");
  endtask

  task automatic test_clean_press();
    button_export[2] = 1'b0;
    repeat (5) tick();
    do_read(2'd1, 32'h0, "press_not_yet");
    do_read(2'd1, 32'h4, "press_button");
    do_read(2'd3, 32'h4, "press_edge");
    tests_run++;
    if (irq !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL press_irq_masked: got %b expected 0", irq);
    end
    do_write(2'd2, 32'h4);
    tests_run++;
    if (irq !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL press_irq_unmasked: got %b expected 1", irq);
    end
    do_write(2'd3, 32'h4);
    tests_run++;
    if (irq !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL press_irq_cleared: got %b expected 0", irq);
    end
    button_export[2] = 1'b1;
    repeat (10) tick();
    do_read(2'd1, 32'h0, "release_button");
    do_read(2'd3, 32'h0, "release_no_edge");
  endtask

  task automatic test_bounce();
    for (int rep = 0; rep < 5; rep++) begin
      button_export[1] = 1'b0;
      repeat (3) tick();
      button_export[1] = 1'b1;
      repeat (3) tick();
    end
    repeat (4) tick();
    do_read(2'd1, 32'h0, "bounce_button");
    do_read(2'd3, 32'h0, "bounce_edge");
    button_export[1] = 1'b0;
    repeat (10) tick();
    do_read(2'd3, 32'h2, "bounce_held_edge");
    do_read(2'd1, 32'h2, "bounce_held_button");
    do_write(2'd3, 32'h2);
    do_read(2'd3, 32'h0, "bounce_once");
    button_export[1] = 1'b1;
    repeat (10) tick();
    do_read(2'd1, 32'h0, "bounce_release");
  endtask

  task automatic test_w1c_race();
    do_write(2'd2, 32'h1);
    button_export[0] = 1'b0;
    repeat (10) tick();
    do_read(2'd3, 32'h1, "race_first_edge");
    button_export[0] = 1'b1;
    repeat (10) tick();
    button_export[0] = 1'b0;
    repeat (6) tick();
    do_write(2'd3, 32'h1);
    do_read(2'd3, 32'h1, "race_set_wins");
    tests_run++;
    if (irq !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL race_irq: got %b expected 1", irq);
    end
    do_write(2'd2, 32'h0);
    tests_run++;
    if (irq !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL mask_zero_irq: got %b expected 0", irq);
    end
    do_write(2'd2, 32'h1);
    tests_run++;
    if (irq !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL mask_one_irq: got %b expected 1", irq);
    end
    do_write(2'd3, 32'h1);
    tests_run++;
    if (irq !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL w1c_irq_drop: got %b expected 0", irq);
    end
    do_read(2'd3, 32'h0, "w1c_cleared");
    button_export[0] = 1'b1;
    repeat (10) tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] e;
    // Write and read of the LED register in the same cycle return the old value.
    avs_address   = 2'd0;
    avs_writedata = 32'h0000_000A;
    avs_write     = 1'b1;
    avs_read      = 1'b1;
    exp_q.push_back(32'h5);
    tick();
    avs_write = 1'b0;
    avs_read  = 1'b0;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    tests_run++;
    if (avs_readdatavalid !== 1'b1 || avs_readdata !== e) begin
      tests_failed++;
      $display("[TB] FAIL rw_same_cycle: got valid=%b data=0x%08h expected valid=1 data=0x%08h",
               avs_readdatavalid, avs_readdata, e);
    end
    tests_run++;
    if (led_export !== 4'hA) begin
      tests_failed++;
      $display("[TB] FAIL rw_led: got 0x%0h expected 0xa", led_export);
    end
    tick();
    // Two reads on consecutive cycles.
    avs_address = 2'd0;
    avs_read    = 1'b1;
    exp_q.push_back(32'hA);
    tick();
    avs_address = 2'd2;
    exp_q.push_back(32'h1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    tests_run++;
    if (avs_readdatavalid !== 1'b1 || avs_readdata !== e) begin
      tests_failed++;
      $display("[TB] FAIL b2b_first: got valid=%b data=0x%08h expected valid=1 data=0x%08h",
               avs_readdatavalid, avs_readdata, e);
    end
    tick();
    avs_read = 1'b0;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    tests_run++;
    if (avs_readdatavalid !== 1'b1 || avs_readdata !== e) begin
      tests_failed++;
      $display("[TB] FAIL b2b_second: got valid=%b data=0x%08h expected valid=1 data=0x%08h",
               avs_readdatavalid, avs_readdata, e);
    end
    tick();
    tests_run++;
    if (avs_readdatavalid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL b2b_idle: got %b expected 0", avs_readdatavalid);
    end
  endtask

  task automatic test_reset_mid();
    button_export[3] = 1'b0;
    repeat (10) tick();
    button_export[3] = 1'b1;
    repeat (10) tick();
    do_write(2'd2, 32'h8);
    tests_run++;
    if (irq !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL pre_reset_irq: got %b expected 1", irq);
    end
    avs_address = 2'd0;
    avs_read    = 1'b1;
    reset_reset = 1'b1;
    tick();
    avs_read = 1'b0;
    tests_run++;
    if (avs_readdatavalid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_read_dropped: got %b expected 0", avs_readdatavalid);
    end
    tick();
    reset_reset = 1'b0;
    tests_run++;
    if (avs_readdatavalid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_no_late_valid: got %b expected 0", avs_readdatavalid);
    end
    tests_run++;
    if (led_export !== 4'h0 || irq !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL mid_reset_outputs: got led=0x%0h irq=%b expected led=0x0 irq=0",
               led_export, irq);
    end
    do_read(2'd0, 32'h0, "mid_reset_led");
    do_read(2'd1, 32'h0, "mid_reset_button");
    do_read(2'd2, 32'h0, "mid_reset_mask");
    do_read(2'd3, 32'h0, "mid_reset_edge");
  endtask

  // Main sequence.
  initial begin
    test_reset();
    test_led_write();
    test_clean_press();
    test_bounce();
    test_w1c_race();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Watchdog so a stuck run still ends.
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] timeout");
  end

endmodule
